crypto_engine_arbiter: RTL and testbench
========================================

CRYPTO_ENGINE_ARBITER -- requirements
Module: crypto_engine_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL set the maximum number of WAIT cycles allowed before engine completion.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_1  input  1  SHALL be the synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  SHALL be requester 0 and requester 1 job requests, held high until the matching grant.
REQ-005 blk0, blk1  input  64 each  SHALL carry each requester's input block, sampled in LOAD.
REQ-006 gnt0, gnt1  output  1 each  SHALL be one-hot grants, high from LOAD through RESP.
REQ-007 eng_start  output  1  SHALL be a one-cycle start pulse to the shared Speck engine.
REQ-008 eng_x  output  64  SHALL be the block presented to the engine, stable from LOAD until the next LOAD.
REQ-009 eng_done  input  1  SHALL be the engine completion pulse.
REQ-010 eng_y  input  64  SHALL be the engine result, valid while eng_done is high.
REQ-011 rsp_valid  output  1  SHALL be a one-cycle result pulse.
REQ-012 rsp_id  output  1  SHALL identify the requester owning rsp_data.
REQ-013 rsp_data  output  64  SHALL be the captured engine result.
REQ-014 timeout  output  1  SHALL be a sticky engine-timeout error flag.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, START, WAIT, RESP and ERR.
REQ-016 IDLE: if req0 or req1 is high, the block SHALL arbitrate and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin on last_served (reset value 1): when both requests are high, the requester not equal to last_served SHALL win; a single request SHALL win outright.
REQ-018 LOAD: the winner's gnt SHALL be high and eng_x SHALL latch the winner's blk; the next state SHALL be START.
REQ-019 START: eng_start SHALL be 1 for exactly this cycle; the timeout counter SHALL clear; the next state SHALL be WAIT.
REQ-020 Latency SHALL be two cycles from the IDLE cycle that sees the request to the eng_start cycle.
REQ-021 WAIT: on eng_done=1, rsp_data SHALL capture eng_y and the next state SHALL be RESP; otherwise the counter SHALL increment.
REQ-022 WAIT: if eng_done=0 and the counter equals TIMEOUT_CYC-1, the next state SHALL be ERR.
REQ-023 If eng_done arrives on the final count cycle, completion SHALL take priority over timeout.
REQ-024 RESP: rsp_valid=1, rsp_id=winner and gnt held; last_served SHALL update to the winner; the next state SHALL be IDLE.
REQ-025 ERR: timeout SHALL be set, gnt SHALL drop, and no rsp_valid SHALL be issued for the job; last_served SHALL update; the next state SHALL be IDLE.
REQ-026 eng_done SHALL be ignored in every state other than WAIT.
REQ-027 Deassertion of req after LOAD SHALL NOT abort the job; it SHALL complete normally.
REQ-028 Changes on blk0 or blk1 after LOAD SHALL NOT affect eng_x for the job in flight.
REQ-029 The counter SHALL be wide enough for TIMEOUT_CYC-1 and SHALL NOT wrap.
REQ-030 At most one job SHALL be in flight; gnt0 and gnt1 SHALL never be high together.

Reset
REQ-031 reset_1=1 at a rising edge SHALL force the following on the next edge: state=IDLE; gnt0=gnt1=0; eng_start=0; rsp_valid=0; rsp_id=0; rsp_data=0; eng_x=0; timeout=0; counter=0; last_served=1.
REQ-032 Reset mid-job SHALL abandon the job with no rsp_valid; a late eng_done after reset SHALL be ignored.
REQ-033 timeout SHALL clear only on reset.

Verification
REQ-034 Single job: req0 with blk0=64'hAD345F789EBC2EF1; engine returns eng_y=64'h6A09E6671A34C678 three cycles after eng_start -> one eng_start pulse two cycles after request, eng_x=64'hAD345F789EBC2EF1, then rsp_valid for one cycle with rsp_id=0 and rsp_data=64'h6A09E6671A34C678.
REQ-035 Contention: req0 and req1 held high from reset -> service order 0,1,0,1; gnt signals one-hot; each job has exactly one eng_start.
REQ-036 Timeout: TIMEOUT_CYC=8 and eng_done never asserted -> ERR entered after 8 WAIT cycles, timeout=1 and sticky, no rsp_valid; a following req1 job completes normally with timeout still 1.
REQ-037 Edge race: eng_done on the 8th WAIT cycle with TIMEOUT_CYC=8 -> RESP, timeout stays 0.
REQ-038 Spurious and reset: eng_done pulsed in IDLE and in START -> ignored; reset_1 asserted in WAIT -> all outputs at reset values next cycle, and a later eng_done produces no rsp_valid.

Source files
------------

// File: rtl/crypto_engine_arbiter.sv
// Two-requester round-robin front end for a shared Speck block-cipher engine.
// One job is in flight at a time: LOAD latches the block, START pulses the
// engine, WAIT bounds the engine latency, and RESP returns the result.
module crypto_engine_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_1,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] blk0,
  input  logic [63:0] blk1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        eng_start,
  output logic [63:0] eng_x,
  input  logic        eng_done,
  input  logic [63:0] eng_y,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        timeout
);

  // Counter only has to reach TIMEOUT_CYC-1; it never counts past that value.
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StResp,
    StErr
  } state_e;

  state_e          state_q, state_d;
  logic            winner_q, winner_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     eng_x_q, eng_x_d;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            rsp_id_q, rsp_id_d;
  logic            timeout_q, timeout_d;
  logic            pick;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  always_comb begin
    pick = req1 & (~req0 | ~last_q);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    eng_x_d    = eng_x_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    timeout_d  = timeout_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    eng_start  = 1'b0;
    rsp_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          winner_d = pick;
          // Block is captured on entry to LOAD so eng_x is already valid there.
          eng_x_d  = pick ? blk1 : blk0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        gnt0    = ~winner_q;
        gnt1    = winner_q;
        state_d = StStart;
      end
      StStart: begin
        gnt0      = ~winner_q;
        gnt1      = winner_q;
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        gnt0 = ~winner_q;
        gnt1 = winner_q;
        // Completion is checked first so a done on the last count still wins.
        if (eng_done) begin
          rsp_data_d = eng_y;
          rsp_id_d   = winner_q;
          state_d    = StResp;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        gnt0      = ~winner_q;
        gnt1      = winner_q;
        rsp_valid = 1'b1;
        last_d    = winner_q;
        state_d   = StIdle;
      end
      StErr: begin
        last_d  = winner_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_1) begin
      state_q    <= StIdle;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      eng_x_q    <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      eng_x_q    <= eng_x_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      timeout_q  <= timeout_d;
    end
  end

  assign eng_x    = eng_x_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_crypto_engine_arbiter.sv
// Bench for crypto_engine_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a job-level reference model.
module tb_crypto_engine_arbiter;

  localparam int unsigned TMO = 8;
  localparam logic [63:0] A  = 64'hAD345F789EBC2EF1;
  localparam logic [63:0] Y  = 64'h6A09E6671A34C678;
  localparam logic [63:0] G  = 64'h0123456789ABCDEF;
  localparam logic [63:0] Z  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] B  = 64'h5555AAAA3333CCCC;
  localparam logic [63:0] Y2 = 64'h0F0F0F0F12345678;
  localparam logic [63:0] K  = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        reset_1, req0, req1, eng_done;
  logic [63:0] blk0, blk1, eng_y;
  logic        gnt0, gnt1, eng_start, rsp_valid, rsp_id, timeout;
  logic [63:0] eng_x, rsp_data;

  int checks = 0;
  int errors = 0;

  crypto_engine_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .reset_1  (reset_1),
    .req0     (req0),
    .req1     (req1),
    .blk0     (blk0),
    .blk1     (blk1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .eng_start(eng_start),
    .eng_x    (eng_x),
    .eng_done (eng_done),
    .eng_y    (eng_y),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, r0, r1;
    logic [63:0] b0, b1;
    logic        dn;
    logic [63:0] y;
    logic        ck, g0, g1, st;
    logic [63:0] x;
    logic        rv, rid;
    logic [63:0] rd;
    logic        tm;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(input logic rst, r0, r1, input logic [63:0] b0, b1,
                              input logic dn, input logic [63:0] y,
                              input logic ck, g0, g1, st, input logic [63:0] x,
                              input logic rv, rid, input logic [63:0] rd, input logic tm);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.b0 = b0; v.b1 = b1; v.dn = dn; v.y = y;
    v.ck = ck; v.g0 = g0; v.g1 = g1; v.st = st; v.x = x; v.rv = rv; v.rid = rid;
    v.rd = rd; v.tm = tm;
    return v;
  endfunction

  function automatic logic [63:0] fx(input logic [63:0] v);
    return {v[31:0], v[63:32]} ^ K;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_1 = 1'b1; req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0; eng_y = '0;
    tick();
    reset_1 = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk1({tag, " gnt0"}, gnt0, 1'b0);
    chk1({tag, " gnt1"}, gnt1, 1'b0);
    chk1({tag, " eng_start"}, eng_start, 1'b0);
    chk64({tag, " eng_x"}, eng_x, 64'd0);
    chk1({tag, " rsp_valid"}, rsp_valid, 1'b0);
    chk1({tag, " rsp_id"}, rsp_id, 1'b0);
    chk64({tag, " rsp_data"}, rsp_data, 64'd0);
    chk1({tag, " timeout"}, timeout, 1'b0);
  endtask

  // Reference model state for the random phase.
  bit          busy, w, m_last, m_tmo, ok, idle_now, exp_g, exp_st, exp_rv;
  int          t0, d, ph, last_ph, wait_end;
  logic [63:0] jb;

  // Contention bookkeeping.
  int          n, starts, cd;
  logic        order[4];
  logic [63:0] rdat[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_1 = 1'b1; req0 = 1'b0; req1 = 1'b0; blk0 = '0; blk1 = '0;
    eng_done = 1'b0; eng_y = '0;

    // Single job, spurious done in START and IDLE, blk change after LOAD.
    tv[0]  = mk(1, 0, 0, 0, 0, 1, G, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(0, 1, 0, A, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 0, 0, A, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 0, Z, 0, 1, G, 1, 1, 0, 1, A, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 0, 0, A, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 0, 0, A, 0, 0, 0, 0);
    tv[6]  = mk(0, 0, 0, Z, 0, 1, Y, 1, 1, 0, 0, A, 0, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, Z, 0, 0, 0, 1, 1, 0, 0, A, 1, 0, Y, 0);
    tv[8]  = mk(0, 0, 0, Z, 0, 1, G, 1, 0, 0, 0, A, 0, 0, Y, 0);
    tv[9]  = mk(0, 0, 0, Z, 0, 0, 0, 1, 0, 0, 0, A, 0, 0, Y, 0);
    tv[10] = mk(0, 0, 0, Z, 0, 0, 0, 1, 0, 0, 0, A, 0, 0, Y, 0);

    for (int i = 0; i < 11; i++) begin
      if (tv[i].ck) begin
        chk1($sformatf("vec%0d gnt0", i), gnt0, tv[i].g0);
        chk1($sformatf("vec%0d gnt1", i), gnt1, tv[i].g1);
        chk1($sformatf("vec%0d eng_start", i), eng_start, tv[i].st);
        chk64($sformatf("vec%0d eng_x", i), eng_x, tv[i].x);
        chk1($sformatf("vec%0d rsp_valid", i), rsp_valid, tv[i].rv);
        chk1($sformatf("vec%0d rsp_id", i), rsp_id, tv[i].rid);
        chk64($sformatf("vec%0d rsp_data", i), rsp_data, tv[i].rd);
        chk1($sformatf("vec%0d timeout", i), timeout, tv[i].tm);
      end
      reset_1 = tv[i].rst; req0 = tv[i].r0; req1 = tv[i].r1;
      blk0 = tv[i].b0; blk1 = tv[i].b1; eng_done = tv[i].dn; eng_y = tv[i].y;
      tick();
    end

    // Contention: both requests held from reset, engine answers after 2 WAITs.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; blk0 = A; blk1 = B;
    n = 0; starts = 0; cd = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      chk1("contention onehot", gnt0 & gnt1, 1'b0);
      if (eng_start) starts++;
      if (rsp_valid) begin
        chk64($sformatf("contention starts job%0d", n), 64'(starts), 64'd1);
        order[n] = rsp_id;
        rdat[n]  = rsp_data;
        starts   = 0;
        n++;
      end
      eng_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_done = 1'b1;
          eng_y    = eng_x ^ K;
        end
      end
      if (eng_start) cd = 2;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; eng_done = 1'b0;
    chk64("contention jobs", 64'(n), 64'd4);
    for (int i = 0; i < n; i++) begin
      chk1($sformatf("contention order%0d", i), order[i], 1'(i % 2));
      chk64($sformatf("contention data%0d", i), rdat[i], ((i % 2) != 0 ? B : A) ^ K);
    end

    // Edge race: done on the final WAIT count completes without timeout.
    do_reset();
    req0 = 1'b1; blk0 = A; tick();
    req0 = 1'b0; tick();
    chk1("race start", eng_start, 1'b1);
    for (int j = 1; j <= TMO; j++) begin
      tick();
      chk1($sformatf("race wait%0d gnt0", j), gnt0, 1'b1);
      chk1($sformatf("race wait%0d rsp_valid", j), rsp_valid, 1'b0);
      eng_done = (j == TMO); eng_y = Y;
    end
    tick();
    chk1("race rsp_valid", rsp_valid, 1'b1);
    chk64("race rsp_data", rsp_data, Y);
    chk1("race timeout", timeout, 1'b0);
    eng_done = 1'b0;
    tick();
    chk1("race idle timeout", timeout, 1'b0);

    // Timeout: no done for TMO WAIT cycles, then a normal job on requester 1.
    do_reset();
    req0 = 1'b1; blk0 = A; tick();
    req0 = 1'b0; tick();
    chk1("tmo start", eng_start, 1'b1);
    for (int j = 1; j <= TMO; j++) begin
      tick();
      chk1($sformatf("tmo wait%0d gnt0", j), gnt0, 1'b1);
      chk1($sformatf("tmo wait%0d timeout", j), timeout, 1'b0);
    end
    tick();
    chk1("tmo err gnt0", gnt0, 1'b0);
    chk1("tmo err rsp_valid", rsp_valid, 1'b0);
    chk1("tmo err timeout", timeout, 1'b1);
    tick();
    chk1("tmo idle timeout", timeout, 1'b1);
    chk1("tmo idle rsp_valid", rsp_valid, 1'b0);
    req1 = 1'b1; blk1 = B; tick();
    chk1("tmo job1 gnt1", gnt1, 1'b1);
    chk1("tmo job1 gnt0", gnt0, 1'b0);
    chk64("tmo job1 eng_x", eng_x, B);
    req1 = 1'b0; tick();
    chk1("tmo job1 start", eng_start, 1'b1);
    tick();
    eng_done = 1'b1; eng_y = Y2; tick();
    eng_done = 1'b0;
    chk1("tmo job1 rsp_valid", rsp_valid, 1'b1);
    chk1("tmo job1 rsp_id", rsp_id, 1'b1);
    chk64("tmo job1 rsp_data", rsp_data, Y2);
    chk1("tmo job1 timeout", timeout, 1'b1);
    tick();
    chk1("tmo sticky", timeout, 1'b1);

    // Reset in WAIT abandons the job and clears the sticky timeout.
    req0 = 1'b1; blk0 = G; tick();
    req0 = 1'b0; tick();
    tick();
    tick();
    reset_1 = 1'b1; tick();
    reset_1 = 1'b0;
    chk_reset_outs("midreset");
    for (int j = 0; j < 3; j++) begin
      eng_done = 1'b1; eng_y = G; tick();
      chk1($sformatf("midreset late%0d rsp_valid", j), rsp_valid, 1'b0);
      chk1($sformatf("midreset late%0d gnt0", j), gnt0, 1'b0);
      chk64($sformatf("midreset late%0d rsp_data", j), rsp_data, 64'd0);
    end
    eng_done = 1'b0;

    // Randomized traffic against a job-level model.
    do_reset();
    busy = 1'b0; m_last = 1'b1; m_tmo = 1'b0; w = 1'b0; d = 1; t0 = 0; jb = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ph       = busy ? cyc - t0 : -1;
      ok       = (d != 0);
      last_ph  = ok ? 3 + d : 3 + int'(TMO);
      wait_end = ok ? 2 + d : 2 + int'(TMO);
      exp_g    = busy && ph >= 1 && (ok ? ph <= last_ph : ph < last_ph);
      exp_st   = busy && ph == 2;
      exp_rv   = busy && ok && ph == last_ph;
      if (busy && !ok && ph == last_ph) m_tmo = 1'b1;

      chk1("rnd gnt0", gnt0, exp_g & ~w);
      chk1("rnd gnt1", gnt1, exp_g & w);
      chk1("rnd eng_start", eng_start, exp_st);
      chk1("rnd rsp_valid", rsp_valid, exp_rv);
      chk1("rnd timeout", timeout, m_tmo);
      if (exp_st) chk64("rnd eng_x", eng_x, jb);
      if (exp_rv) begin
        chk1("rnd rsp_id", rsp_id, w);
        chk64("rnd rsp_data", rsp_data, fx(jb));
      end

      idle_now = !busy;

      if (!req0) begin
        if ($urandom_range(0, 3) == 0) begin req0 = 1'b1; blk0 = rand64(); end
      end else if (exp_g && !w) begin
        blk0 = rand64();
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom_range(0, 3) == 0) begin req1 = 1'b1; blk1 = rand64(); end
      end else if (exp_g && w) begin
        blk1 = rand64();
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
      end

      eng_done = 1'b0;
      eng_y    = rand64();
      if (busy && ok && ph == 2 + d) begin
        eng_done = 1'b1;
        eng_y    = fx(jb);
      end else if (!(busy && ph >= 3 && ph <= wait_end)) begin
        if ($urandom_range(0, 7) == 0) eng_done = 1'b1;
      end

      if (busy && ph == last_ph) begin
        busy   = 1'b0;
        m_last = w;
      end
      if (idle_now && (req0 || req1)) begin
        w    = (req0 && req1) ? ~m_last : req1;
        jb   = w ? blk1 : blk0;
        t0   = cyc;
        busy = 1'b1;
        d    = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TMO));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
